// File: rtl/alarm_controller.sv
// Alarm unit of the morning clock: holds the programmed alarm time and runs the
// arm/ring/snooze state machine that drives the ring flag and the buzzer tone.
module alarm_controller #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int TONE_HALF  = 25000
) (
    input  logic       clk,
    input  logic       x_clr,
    input  logic       sec_tick,
    input  logic [5:0] time_sec,
    input  logic [5:0] time_min,
    input  logic [4:0] time_hour,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    output logic       set_err,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       armed,
    output logic       ring,
    output logic       buzz,
    output logic [1:0] state,
    output logic [1:0] snooze_left
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] RINGING = 2'd2;
    localparam logic [1:0] SNOOZE  = 2'd3;

    localparam int RING_W = $clog2(RING_SEC + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);
    localparam int TONE_W = $clog2(TONE_HALF);

    localparam logic [RING_W-1:0] RING_END  = RING_W'(RING_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(1);
    localparam logic [TONE_W-1:0] TONE_END  = TONE_W'(TONE_HALF - 1);
    localparam logic [1:0]        LEFT_MAX  = 2'(MAX_SNOOZE);

    logic [RING_W-1:0] ring_cnt;
    logic [SNZ_W-1:0]  snz_cnt;
    logic [TONE_W-1:0] tone_cnt;

    logic [1:0]        next_state;
    logic [1:0]        next_left;
    logic [RING_W-1:0] next_ring_cnt;
    logic [SNZ_W-1:0]  next_snz_cnt;

    logic set_take;
    logic set_ok;
    logic set_load;
    logic alarm_match;

    // Handshake: a set transfers on any cycle where set_valid and set_ready are both high.
    assign set_take    = set_valid & set_ready;
    assign set_ok      = (set_hour < 5'd24) && (set_min < 6'd60);
    assign set_load    = set_take & set_ok;
    assign alarm_match = sec_tick && (time_hour == alarm_hour) &&
                         (time_min == alarm_min) && (time_sec == 6'd0);

    always_comb begin
        next_state    = state;
        next_left     = snooze_left;
        next_ring_cnt = ring_cnt;
        next_snz_cnt  = snz_cnt;
        // A good set overrides everything else, including a same-cycle match.
        if (set_load) begin
            next_state = set_en ? ARMED : IDLE;
            next_left  = LEFT_MAX;
        end else begin
            case (state)
                ARMED: begin
                    if (alarm_match) begin
                        next_state    = RINGING;
                        next_ring_cnt = '0;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        next_state = ARMED;
                        next_left  = LEFT_MAX;
                    end else if (snooze_btn && (snooze_left != 2'd0)) begin
                        next_state   = SNOOZE;
                        next_snz_cnt = SNZ_LOAD;
                        next_left    = snooze_left - 2'd1;
                    end else if (sec_tick) begin
                        next_ring_cnt = ring_cnt + 1'b1;
                        if (ring_cnt == RING_END) begin
                            next_state = ARMED;
                            next_left  = LEFT_MAX;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        next_state = ARMED;
                        next_left  = LEFT_MAX;
                    end else if (sec_tick) begin
                        next_snz_cnt = snz_cnt - 1'b1;
                        if (snz_cnt == SNZ_LAST) begin
                            next_state    = RINGING;
                            next_ring_cnt = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge x_clr) begin
        if (x_clr) begin
            state       <= IDLE;
            snooze_left <= LEFT_MAX;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            alarm_hour  <= '0;
            alarm_min   <= '0;
            set_err     <= 1'b0;
            set_ready   <= 1'b1;
            armed       <= 1'b0;
            ring        <= 1'b0;
        end else begin
            state       <= next_state;
            snooze_left <= next_left;
            ring_cnt    <= next_ring_cnt;
            snz_cnt     <= next_snz_cnt;
            if (set_load) begin
                alarm_hour <= set_hour;
                alarm_min  <= set_min;
            end
            set_err   <= set_take & ~set_ok;
            set_ready <= (next_state != RINGING);
            armed     <= (next_state != IDLE);
            ring      <= (next_state == RINGING);
        end
    end

    // Tone divider runs only while staying in RINGING; entering or leaving restarts it silent.
    always_ff @(posedge clk or posedge x_clr) begin
        if (x_clr) begin
            tone_cnt <= '0;
            buzz     <= 1'b0;
        end else if ((state == RINGING) && (next_state == RINGING)) begin
            if (tone_cnt == TONE_END) begin
                tone_cnt <= '0;
                buzz     <= ~buzz;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end else begin
            tone_cnt <= '0;
            buzz     <= 1'b0;
        end
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Consumer of the time-base counters: the alarm unit of the morning clock.
- Reads seconds/minutes/hours from the time base and holds a user-programmed alarm time.
- Runs an arm/ring/snooze state machine and drives the ring flag and buzzer tone.
- Sits in the fast `clk` domain, between the time base and the buzzer/LED pins.

Parameters:
- RING_SEC, 60: seconds a ring lasts before it times out and returns to ARMED.
- SNOOZE_SEC, 300: snooze interval in seconds.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.
- TONE_HALF, 25000: `clk` cycles per half-period of the buzz square wave (1 kHz at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- x_clr  in  1  asynchronous, active-high reset.
- sec_tick  in  1  one-`clk` pulse per second; time inputs are stable whenever it is high.
- time_sec  in  6  current seconds, 0-59.
- time_min  in  6  current minutes, 0-59.
- time_hour  in  5  current hours, 0-23.
- set_valid  in  1  alarm-set request.
- set_ready  out  1  set request can be accepted.
- set_en  in  1  arm (1) or disarm (0) with this set.
- set_hour  in  5  requested alarm hour.
- set_min  in  6  requested alarm minute.
- set_err  out  1  one-cycle pulse: set rejected as out of range.
- snooze_btn  in  1  one-cycle pulse, debounced.
- stop_btn  in  1  one-cycle pulse, debounced.
- alarm_hour  out  5  stored alarm hour.
- alarm_min  out  6  stored alarm minute.
- armed  out  1  state is not IDLE.
- ring  out  1  state is RINGING.
- buzz  out  1  tone output.
- state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- snooze_left  out  2  snoozes remaining.

Behaviour:
- Reset (async, x_clr=1):
  - state=IDLE; alarm_hour=0, alarm_min=0.
  - ring=0, buzz=0, set_err=0, set_ready=1, snooze_left=MAX_SNOOZE.
  - Internal ring and snooze counters = 0.
  - Reset mid-ring silences the buzzer immediately; no cycle delay.
- All outputs are registered.
- set_ready=0 in RINGING, 1 in every other state.
- Set handshake: a transfer happens on a cycle with set_valid=1 and set_ready=1.
  - Range check: set_hour<24 and set_min<60 is required; values are checked with no wrapping.
  - Out of range: set_err=1 on the next cycle, and nothing else changes.
  - In range: alarm_hour/alarm_min load on the next edge.
  - Next state is ARMED if set_en=1, else IDLE; this applies from IDLE, ARMED or SNOOZE.
  - An accepted set also reloads snooze_left=MAX_SNOOZE.
  - A set request while set_ready=0 is ignored; no error is raised.
- Match: in ARMED, a cycle with sec_tick=1, time_hour==alarm_hour, time_min==alarm_min and time_sec==0 moves the state to RINGING on the next edge.
  - Entering RINGING clears the ring counter.
  - If an accepted set and a match fall in the same cycle, the set wins and there is no ring.
- RINGING, checked in priority order:
  - stop_btn → ARMED, snooze_left=MAX_SNOOZE.
  - snooze_btn with snooze_left>0 → SNOOZE; snooze counter=SNOOZE_SEC; snooze_left decrements.
  - snooze_btn with snooze_left=0 is ignored.
  - sec_tick increments the ring counter; when it reaches RING_SEC → ARMED, snooze_left=MAX_SNOOZE.
  - stop_btn and snooze_btn in the same cycle: stop wins.
- SNOOZE:
  - sec_tick decrements the snooze counter.
  - A tick that arrives with the counter at 1 → RINGING; the ring counter clears.
  - stop_btn → ARMED, snooze_left=MAX_SNOOZE.
  - snooze_btn is ignored.
  - The match comparison is disabled.
- IDLE: only an accepted set with set_en=1 leaves IDLE.
- buzz:
  - 0 outside RINGING.
  - On RINGING entry, buzz=0 and the tone divider clears.
  - buzz toggles every TONE_HALF cycles while RINGING; it goes to 0 on the edge that leaves RINGING.
- Counter widths:
  - $clog2(RING_SEC+1), $clog2(SNOOZE_SEC+1) and $clog2(TONE_HALF) bits.
  - No counter may wrap: saturation is unreachable given the transitions above.
- sec_tick at time_sec==0 while in RINGING or SNOOZE does not retrigger a ring.

Test Plan:
- Reset, then set 07:30 en=1 → armed=1, alarm_hour=7, alarm_min=30, state=1. Drive ticks to 07:29:59 → ring=0. Tick 07:30:00 → ring=1 next cycle, buzz toggles every TONE_HALF cycles.
- Set hour=24 min=10 → set_err pulses once; alarm registers and state are unchanged. Set min=60 → same result.
- Ring, then snooze_btn → state=3, ring=0, snooze_left=2. After 300 ticks → ring=1. Repeat 3 snoozes → the 4th snooze_btn is ignored and the ring stays on. After 60 ticks → ARMED, snooze_left=3.
- During RINGING, drive stop_btn and snooze_btn in the same cycle → state=ARMED, buzz=0.
- During RINGING, pulse set_valid → set_ready=0 and alarm_min is unchanged. Assert x_clr mid-ring → ring=0, buzz=0 immediately, state=IDLE.
- In ARMED, drive an accepted set en=0 in the same cycle as the matching 07:30:00 tick → state=IDLE, no ring.
